// File: rtl/game_pkg.sv
// Shared codes for the game controller, the bird FSM and the renderer.
package game_pkg;

   typedef enum logic [2:0] {
      BIRD_INITIAL = 3'd0,
      BIRD_ASC     = 3'd1,
      BIRD_DESC    = 3'd2,
      BIRD_JUMPING = 3'd3,
      BIRD_FALLING = 3'd4,
      BIRD_DYING   = 3'd5
   } bird_state_t;

   typedef enum logic [2:0] {
      G_IDLE      = 3'd0,
      G_STARTING  = 3'd1,
      G_PLAYING   = 3'd2,
      G_KILLING   = 3'd3,
      G_OVER      = 3'd4,
      G_RESETTING = 3'd5
   } game_state_t;

   localparam int GAME_SCORE_W = 14;

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector on an already-debounced level.
// Captures the level every clock and flags when it goes from low to high.
module rise_edge (
   input  logic clk_100Hz,
   input  logic rst,
   input  logic level,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk_100Hz) begin
      if (rst) begin
         prev <= 1'b0;
      end else begin
         prev <= level;
      end
   end

   assign rise = level & ~prev;

endmodule

// File: rtl/game_ctrl.sv
// Game-level controller: turns key and collision levels into bird commands.
// Each held command waits for the bird's state code to acknowledge it. The block also tracks score and best.
module game_ctrl
   import game_pkg::*;
#(
   parameter int SCORE_DIV = 100,
   parameter int OVER_HOLD = 100,
   parameter int SCORE_W   = GAME_SCORE_W
) (
   input  logic               clk_100Hz,
   input  logic               rst,
   input  logic               key_start,
   input  logic               key_jump,
   input  logic               key_fall,
   input  logic               collide,
   input  logic [2:0]         bird_state,
   output logic               bird_start,
   output logic               bird_rst,
   output logic               bird_jump,
   output logic               bird_fall,
   output logic               bird_kill,
   output logic [2:0]         game_state,
   output logic [SCORE_W-1:0] score,
   output logic [SCORE_W-1:0] best
);

   localparam int TICK_W = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
   localparam int HOLD_W = $clog2(OVER_HOLD + 1);
   localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(SCORE_DIV - 1);
   localparam logic [HOLD_W-1:0]  HOLD_DONE = HOLD_W'(OVER_HOLD);
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   game_state_t        state;
   logic               start_rise;
   logic               jump_rise;
   logic               fall_rise;
   logic               jump_pend;
   logic               fall_pend;
   logic               jump_next;
   logic               fall_next;
   logic               bird_ready;
   logic [TICK_W-1:0]  tick_cnt;
   logic [HOLD_W-1:0]  hold_cnt;

   rise_edge u_start_edge (
      .clk_100Hz (clk_100Hz),
      .rst       (rst),
      .level     (key_start),
      .rise      (start_rise)
   );

   rise_edge u_jump_edge (
      .clk_100Hz (clk_100Hz),
      .rst       (rst),
      .level     (key_jump),
      .rise      (jump_rise)
   );

   rise_edge u_fall_edge (
      .clk_100Hz (clk_100Hz),
      .rst       (rst),
      .level     (key_fall),
      .rise      (fall_rise)
   );

   // The newest key edge replaces whatever command is still waiting; jump beats fall on a tie.
   always_comb begin
      jump_next = jump_pend;
      fall_next = fall_pend;
      if (jump_rise) begin
         jump_next = 1'b1;
         fall_next = 1'b0;
      end else if (fall_rise) begin
         jump_next = 1'b0;
         fall_next = 1'b1;
      end
   end

   assign bird_ready = (bird_state == BIRD_ASC) || (bird_state == BIRD_DESC);
   assign game_state = state;

   always_ff @(posedge clk_100Hz) begin
      if (rst) begin
         state      <= G_RESETTING;
         bird_rst   <= 1'b1;
         bird_start <= 1'b0;
         bird_jump  <= 1'b0;
         bird_fall  <= 1'b0;
         bird_kill  <= 1'b0;
         score      <= '0;
         best       <= '0;
         jump_pend  <= 1'b0;
         fall_pend  <= 1'b0;
         tick_cnt   <= '0;
         hold_cnt   <= '0;
      end else begin
         bird_jump <= 1'b0;
         bird_fall <= 1'b0;
         case (state)
            G_IDLE: begin
               if (start_rise) begin
                  state      <= G_STARTING;
                  bird_start <= 1'b1;
                  score      <= '0;
                  tick_cnt   <= '0;
               end
            end

            G_STARTING: begin
               if (bird_state != BIRD_INITIAL) begin
                  state      <= G_PLAYING;
                  bird_start <= 1'b0;
                  jump_pend  <= 1'b0;
                  fall_pend  <= 1'b0;
               end
            end

            G_PLAYING: begin
               // A collision overrides any command that would have gone out this cycle.
               if (collide) begin
                  state     <= G_KILLING;
                  bird_kill <= 1'b1;
                  jump_pend <= 1'b0;
                  fall_pend <= 1'b0;
               end else begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     if (score != SCORE_MAX) begin
                        score <= score + 1'b1;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end

                  if (bird_ready && jump_next) begin
                     bird_jump <= 1'b1;
                     jump_pend <= 1'b0;
                     fall_pend <= 1'b0;
                  end else if (bird_ready && fall_next) begin
                     bird_fall <= 1'b1;
                     jump_pend <= 1'b0;
                     fall_pend <= 1'b0;
                  end else begin
                     jump_pend <= jump_next;
                     fall_pend <= fall_next;
                  end
               end
            end

            G_KILLING: begin
               if (bird_state == BIRD_DYING) begin
                  state     <= G_OVER;
                  bird_kill <= 1'b0;
                  hold_cnt  <= '0;
                  if (score > best) begin
                     best <= score;
                  end
               end
            end

            G_OVER: begin
               if (hold_cnt != HOLD_DONE) begin
                  hold_cnt <= hold_cnt + 1'b1;
               end else if (start_rise) begin
                  state    <= G_RESETTING;
                  bird_rst <= 1'b1;
               end
            end

            G_RESETTING: begin
               if (bird_state == BIRD_INITIAL) begin
                  state    <= G_IDLE;
                  bird_rst <= 1'b0;
               end
            end

            default: begin
               state      <= G_RESETTING;
               bird_rst   <= 1'b1;
               bird_start <= 1'b0;
               bird_kill  <= 1'b0;
            end
         endcase
      end
   end

endmodule
